// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM state values and
// the frame length used when sizing the watchdog.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Start + 8 data + parity + stop; TIMEOUT_CYCLES must cover this many bit periods.
    localparam int FRAME_BITS = 11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after lastIdx, wrapping
// at NUM_REQ. Returns both one-hot and index forms of the winner.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [IDX_WIDTH-1:0] lastIdx,
    output logic [NUM_REQ-1:0]   grantOh,
    output logic [IDX_WIDTH-1:0] grantIdx,
    output logic                 grantValid
);
    localparam int SEL_W = $clog2(NUM_REQ);

    int               cand;
    logic [SEL_W-1:0] sel;

    always_comb begin
        grantOh    = '0;
        grantIdx   = lastIdx;
        grantValid = 1'b0;
        cand       = 0;
        sel        = '0;
        // Offsets 1..NUM_REQ so the last winner is considered only after everyone else.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(lastIdx) + k) % NUM_REQ;
            sel  = SEL_W'(cand);
            if (!grantValid && reqValid[sel]) begin
                grantValid = 1'b1;
                grantIdx   = IDX_WIDTH'(cand);
                grantOh    = '0;
                grantOh[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources: round-robin grant,
// enable held for one frame, forced low-enable gap, and a SEND watchdog.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int TO_WIDTH       = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     reqValid,
    input  logic [NUM_REQ*8-1:0]   reqData,
    output logic [NUM_REQ-1:0]     reqReady,
    output logic                   txEnable,
    output logic [7:0]             txByte,
    input  logic                   txDone,
    output logic                   busy,
    output logic [IDX_WIDTH-1:0]   grantIdx,
    output logic                   timeoutErr
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t               state, stateNext;
    logic [GAP_W-1:0]     gapCnt, gapCntNext;
    logic [TO_WIDTH-1:0]  toCnt, toCntNext;
    logic [IDX_WIDTH-1:0] grantIdxNext;
    logic [7:0]           txByteNext;
    logic [NUM_REQ-1:0]   reqReadyNext;

    logic [NUM_REQ-1:0]   arbOh;
    logic [IDX_WIDTH-1:0] arbIdx;
    logic                 arbValid;
    logic [7:0]           arbByte;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_WIDTH(IDX_WIDTH)
    ) uArb (
        .reqValid  (reqValid),
        .lastIdx   (grantIdx),
        .grantOh   (arbOh),
        .grantIdx  (arbIdx),
        .grantValid(arbValid)
    );

    always_comb begin
        arbByte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arbOh[i]) arbByte = reqData[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gapCnt   <= '0;
            toCnt    <= '0;
            grantIdx <= IDX_WIDTH'(NUM_REQ - 1);
            txByte   <= 8'h00;
            reqReady <= '0;
        end else begin
            state    <= stateNext;
            gapCnt   <= gapCntNext;
            toCnt    <= toCntNext;
            grantIdx <= grantIdxNext;
            txByte   <= txByteNext;
            reqReady <= reqReadyNext;
        end
    end

    always_comb begin
        stateNext    = state;
        gapCntNext   = gapCnt;
        toCntNext    = toCnt;
        grantIdxNext = grantIdx;
        txByteNext   = txByte;
        reqReadyNext = '0;
        timeoutErr   = 1'b0;
        case (state)
            IDLE: begin
                if (arbValid) begin
                    stateNext    = SEND;
                    grantIdxNext = arbIdx;
                    txByteNext   = arbByte;
                    reqReadyNext = arbOh;
                    toCntNext    = '0;
                end
            end
            SEND: begin
                // A completed frame beats a simultaneous watchdog expiry.
                if (txDone) begin
                    stateNext  = GAP;
                    gapCntNext = GAP_W'(GAP_CYCLES);
                    toCntNext  = '0;
                end else if (toCnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    timeoutErr = 1'b1;
                    stateNext  = GAP;
                    gapCntNext = GAP_W'(GAP_CYCLES);
                    toCntNext  = '0;
                end else begin
                    toCntNext = toCnt + TO_WIDTH'(1);
                end
            end
            GAP: begin
                gapCntNext = gapCnt - GAP_W'(1);
                if (gapCnt <= GAP_W'(1)) begin
                    stateNext  = IDLE;
                    gapCntNext = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign txEnable = (state == SEND);
    assign busy     = (state != IDLE);

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources. It grants one requester at a time and latches its byte. It holds the transmitter enable high for the whole frame, then waits for the one-cycle done pulse. Afterwards it forces a low-enable gap so the transmitter's frame counter returns to its idle state before the next byte. It sits between the packet/command sources and the UART TX datapath, and includes a watchdog that recovers from a frame that never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_WIDTH, 2, width of grant index; must be >= clog2(NUM_REQ)
GAP_CYCLES, 4, clock cycles txEnable is held low after each txDone (>= 1)
TIMEOUT_CYCLES, 16384, cycles in SEND without txDone before abort; must exceed 11 bit periods at CLKFREQ/BAUDRATE
TO_WIDTH, 15, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
reqValid  in  NUM_REQ  requester i has a byte pending; held until reqReady[i]
reqData  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i]; stable while reqValid[i]
reqReady  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
txEnable  out  1  to transmitter enable; high for exactly one frame
txByte  out  8  to transmitter byte input; constant while txEnable high
txDone  in  1  transmitter frame-complete pulse (one cycle)
busy  out  1  high in any state other than IDLE
grantIdx  out  IDX_WIDTH  index of the requester being served (last served when idle)
timeoutErr  out  1  one-cycle pulse when watchdog aborts a frame

Behaviour:
- Reset:
  - Clock, and reset synchronous active-high, exactly as listed under Ports.
  - On reset: state=IDLE, txEnable=0, txByte=8'h00, reqReady=0, busy=0, grantIdx=NUM_REQ-1 (so requester 0 has first priority), timeoutErr=0, counters=0.
  - Reset mid-frame drops txEnable in the next cycle. The transmitter aborts its frame; no reqReady is issued for the aborted byte if it was not yet issued.
- States: IDLE, SEND, GAP.
- IDLE:
  - If |reqValid at edge n: pick the first i with reqValid[i], searching from grantIdx+1 upward with wrap (modulo NUM_REQ).
  - Register grantIdx=i and txByte=reqData[i]; pulse reqReady[i] in cycle n+1; set txEnable=1 from cycle n+1; go to SEND.
  - Grant latency is 1 cycle. Only one reqReady bit is ever high.
- SEND:
  - txEnable=1 and txByte held.
  - On txDone=1: txEnable=0 next cycle; load gap counter with GAP_CYCLES; go to GAP.
  - Watchdog counts cycles in SEND. On reaching TIMEOUT_CYCLES-1 without txDone: pulse timeoutErr, txEnable=0, go to GAP.
  - txDone and timeout in the same cycle: txDone wins, no timeoutErr.
  - reqValid changes are ignored in SEND.
- GAP:
  - txEnable=0. Decrement the counter each cycle; at 0 go to IDLE.
  - Arbitration happens in IDLE only, so back-to-back bytes are separated by GAP_CYCLES+1 cycles of txEnable low.
- txDone outside SEND is ignored.
- Fairness: a requester holding reqValid continuously is granted within NUM_REQ frames.
- NUM_REQ not a power of two: the search wraps at NUM_REQ; grantIdx never exceeds NUM_REQ-1.

Decomposition:
- Shared package (uart_pkg): state encoding constants (IDLE=2'd0, SEND=2'd1, GAP=2'd2) and the default frame constant FRAME_BITS=11 used to size TIMEOUT_CYCLES.
- One natural sub-module, rr_arbiter: combinational round-robin priority pick. Inputs are reqValid and last grant; outputs are the one-hot grant and the index. Reusable by other shared resources.

Test Plan:
1. Single byte: reqValid=4'b0001, reqData[7:0]=8'hA5 → reqReady=4'b0001 one cycle after request; txEnable high, txByte=8'hA5 until model txDone; then txEnable low for exactly 4 cycles before the next grant is possible; busy then low.
2. Round robin: all four valid with bytes 8'h10/8'h11/8'h12/8'h13 held → grant order 0,1,2,3,0; txByte sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
3. Skip idle requesters: reqValid=4'b1010 after reset → grants 1,3,1,3; reqReady never pulses on bits 0 or 2.
4. Watchdog: grant requester 2, model never asserts txDone → timeoutErr pulses at SEND cycle 16384; txEnable low next cycle; after GAP the next grant goes to requester 3 if valid.
5. Simultaneous txDone and watchdog expiry in the same cycle → no timeoutErr; normal GAP.
6. Reset mid-frame: reset=1 during SEND → next cycle txEnable=0, busy=0, grantIdx=3; first post-reset grant goes to requester 0.
